// File: rtl/car_park_gate_ctrl_pkg.sv
// rtl/car_park_gate_ctrl_pkg.sv - shared state encoding and lane IDs for the car park gate controller
// Contents:
//   gate_state_t : controller FSM states
//   ENTRY / EXIT : lane identifiers stored in last_grant
package car_park_gate_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENTRY_PASS = 3'd1,
        ENTRY_OPEN = 3'd2,
        EXIT_OPEN  = 3'd3,
        CLOSE      = 3'd4,
        LOCKED     = 3'd5
    } gate_state_t;

    localparam logic ENTRY = 1'b0;
    localparam logic EXIT  = 1'b1;

endpackage

// File: rtl/car_park_gate_occupancy_counter.sv
// rtl/car_park_gate_occupancy_counter.sv - saturating up/down car counter
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   inc, dec   : count one car in / out (simultaneous requests cancel)
//   occupancy  : current count, held within 0..CAPACITY
//   full       : occupancy == CAPACITY
module gate_occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] occupancy,
    output logic             full
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (inc && !dec && occupancy != CAP) begin
            occupancy <= occupancy + ONE;
        end else if (dec && !inc && occupancy != '0) begin
            occupancy <= occupancy - ONE;
        end
    end

    assign full = (occupancy == CAP);

endmodule

// File: rtl/car_park_gate_ctrl.sv
// rtl/car_park_gate_ctrl.sv - shared barrier gate controller: lane arbitration, password check, occupancy
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   entry_req, exit_req     : car waiting at entry / exit lane (level)
//   pass_valid, pass_in     : password strobe and nibble
//   car_clear               : car has passed the barrier (pulse)
//   gate_open               : barrier raise command
//   grant_entry, grant_exit : lane currently owning the gate
//   wrong_pass              : pulse on each incorrect password
//   lockout                 : entry lane locked out
//   occupancy, full         : car count and count == CAPACITY
module car_park_gate_ctrl
    import car_park_gate_ctrl_pkg::*;
#(
    parameter int         CAPACITY    = 8,
    parameter int         CNT_W       = 4,
    parameter logic [3:0] PASSWORD    = 4'b1011,
    parameter int         MAX_TRIES   = 3,
    parameter int         GATE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_valid,
    input  logic [3:0]       pass_in,
    input  logic             car_clear,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic             wrong_pass,
    output logic             lockout,
    output logic [CNT_W-1:0] occupancy,
    output logic             full
);

    localparam int TMR_W = $clog2(GATE_CYCLES);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

    gate_state_t      state, state_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic [TRY_W-1:0] tries, tries_d, tries_inc;
    logic             last_grant, last_grant_d;
    logic             lockout_q, lockout_d;
    logic             entry_ok, exit_ok, timeout, timed, restart;
    logic             occ_inc, occ_dec;

    assign entry_ok  = entry_req && !full && !lockout_q;
    assign exit_ok   = exit_req && (occupancy != '0);
    assign timeout   = (timer == TMR_LAST);
    assign tries_inc = tries + TRY_ONE;
    assign timed     = (state == ENTRY_PASS) || (state == ENTRY_OPEN) || (state == EXIT_OPEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            tries      <= '0;
            last_grant <= EXIT;
            lockout_q  <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            tries      <= tries_d;
            last_grant <= last_grant_d;
            lockout_q  <= lockout_d;
        end
    end

    always_comb begin
        state_d      = state;
        tries_d      = tries;
        last_grant_d = last_grant;
        lockout_d    = lockout_q;
        restart      = 1'b0;
        wrong_pass   = 1'b0;
        occ_inc      = 1'b0;
        occ_dec      = 1'b0;

        case (state)
            IDLE: begin
                // Round-robin: entry wins a tie only if exit was served last.
                if (entry_ok && (!exit_ok || last_grant == EXIT)) begin
                    state_d      = ENTRY_PASS;
                    last_grant_d = ENTRY;
                end else if (exit_ok) begin
                    state_d      = EXIT_OPEN;
                    last_grant_d = EXIT;
                end
            end
            ENTRY_PASS: begin
                if (pass_valid) begin
                    if (pass_in == PASSWORD) begin
                        state_d = ENTRY_OPEN;
                        tries_d = '0;
                    end else begin
                        wrong_pass = 1'b1;
                        tries_d    = tries_inc;
                        restart    = 1'b1;
                        if (tries_inc == TRY_MAX) begin
                            state_d   = LOCKED;
                            lockout_d = 1'b1;
                        end
                    end
                end else if (!entry_req || timeout) begin
                    state_d = IDLE;
                end
            end
            ENTRY_OPEN: begin
                if (car_clear) begin
                    occ_inc = 1'b1;
                    state_d = CLOSE;
                end else if (timeout) begin
                    state_d = CLOSE;
                end
            end
            EXIT_OPEN: begin
                if (car_clear) begin
                    occ_dec = 1'b1;
                    state_d = CLOSE;
                end else if (timeout) begin
                    state_d = CLOSE;
                end
            end
            CLOSE:   state_d = IDLE;
            LOCKED:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The lockout flag lives outside the FSM so exits keep flowing while
        // entry is barred; a car leaving the entry lane releases it.
        if (lockout_q && !entry_req) begin
            lockout_d = 1'b0;
            tries_d   = '0;
        end

        if (state_d != state || restart || !timed) begin
            timer_d = '0;
        end else begin
            timer_d = timer + TMR_ONE;
        end
    end

    gate_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk       (clk),
        .rst       (rst),
        .inc       (occ_inc),
        .dec       (occ_dec),
        .occupancy (occupancy),
        .full      (full)
    );

    assign gate_open   = (state == ENTRY_OPEN) || (state == EXIT_OPEN);
    assign grant_entry = (state == ENTRY_PASS) || (state == ENTRY_OPEN);
    assign grant_exit  = (state == EXIT_OPEN);
    assign lockout     = lockout_q;

endmodule
